// File: rtl/pwm_ramp_sequencer.sv
// Sweeps a bank of PWM driver channels, ramping each channel's duty toward its host target and
// issuing serialised {duty, period} loads. Define PWM_RAMP_SEQ_IRQ_EN to add the sweep_irq output.

module pwm_ramp_lane #(
    parameter int STEP = 8
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [15:0] wr_data,
    input  logic        svc,
    output logic        settled,
    output logic [7:0]  next_duty,
    output logic [7:0]  next_period
);
    logic [7:0] tgt_duty, tgt_period, cur_duty, cur_period;
    logic [8:0] up, dn;

    // 9-bit sums so the ramp can never wrap past 0 or 255
    always_comb begin
        up = {1'b0, cur_duty} + 9'(STEP);
        dn = {1'b0, cur_duty} - 9'(STEP);
        if (tgt_duty > cur_duty)
            next_duty = (up > {1'b0, tgt_duty}) ? tgt_duty : up[7:0];
        else
            next_duty = (dn[8] || dn < {1'b0, tgt_duty}) ? tgt_duty : dn[7:0];
    end

    assign next_period = tgt_period;
    assign settled     = (cur_duty == tgt_duty) && (cur_period == tgt_period);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            tgt_duty   <= '0;
            tgt_period <= '0;
            cur_duty   <= '0;
            cur_period <= '0;
        end else begin
            if (wr) begin
                tgt_duty   <= wr_data[15:8];
                tgt_period <= wr_data[7:0];
            end
            if (svc) begin
                cur_duty   <= next_duty;
                cur_period <= next_period;
            end
        end
    end
endmodule

module pwm_ramp_sequencer #(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int STEP     = 8,
    parameter int TICK_DIV = 1000
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_chan,
    input  logic [15:0]       wr_data,
    output logic              wr_ready,
    output logic [15:0]       pwm_data,
    output logic [NUM_CH-1:0] pwm_load,
    output logic              busy,
    output logic [NUM_CH-1:0] settled
`ifdef PWM_RAMP_SEQ_IRQ_EN
    ,
    output logic              sweep_irq
`endif
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, LOAD, HOLD} state_t;

    state_t                   state, state_nxt;
    logic [CH_W-1:0]          ch, ch_nxt;
    logic [CNT_W-1:0]         cnt;
    logic                     tick, pending, ready_q, start, enter_load, last, cur_settled;
    logic                     wr_acc;
    logic [NUM_CH-1:0]        sel, lane_wr, svc;
    logic [NUM_CH-1:0][7:0]   nd, np;
    logic [7:0]               sel_nd, sel_np;

    assign tick   = (cnt == CNT_W'(TICK_DIV - 1));
    assign busy   = (state != IDLE);
    assign last   = (ch == CH_W'(NUM_CH - 1));
    // The channel being loaded/held cannot take a new target until its load strobe has finished
    assign wr_ready = ready_q && !(((state == LOAD) || (state == HOLD)) && (wr_chan == ch));
    assign wr_acc   = wr_en && wr_ready;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_lane
            assign sel[i]     = (ch == CH_W'(i));
            assign lane_wr[i] = wr_acc && (wr_chan == CH_W'(i));
            pwm_ramp_lane #(.STEP(STEP)) u_lane (
                .sys_clk     (sys_clk),
                .reset       (reset),
                .wr          (lane_wr[i]),
                .wr_data     (wr_data),
                .svc         (svc[i]),
                .settled     (settled[i]),
                .next_duty   (nd[i]),
                .next_period (np[i])
            );
        end
    endgenerate

    always_comb begin
        sel_nd = '0;
        sel_np = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel[k]) begin
                sel_nd = nd[k];
                sel_np = np[k];
            end
        end
    end

    assign cur_settled = |(settled & sel);
    assign svc         = sel & {NUM_CH{enter_load}};

    always_comb begin
        state_nxt  = state;
        ch_nxt     = ch;
        start      = 1'b0;
        enter_load = 1'b0;
        case (state)
            IDLE: if (tick || pending) begin
                state_nxt = SCAN;
                ch_nxt    = '0;
                start     = 1'b1;
            end
            SCAN: begin
                if (!cur_settled) begin
                    enter_load = 1'b1;
                    state_nxt  = LOAD;
                end else if (last) begin
                    state_nxt = IDLE;
                end else begin
                    ch_nxt = ch + 1'b1;
                end
            end
            LOAD: state_nxt = HOLD;
            HOLD: begin
                if (last) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SCAN;
                    ch_nxt    = ch + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ch       <= '0;
            cnt      <= '0;
            pending  <= 1'b0;
            ready_q  <= 1'b0;
            pwm_data <= '0;
            pwm_load <= '0;
        end else begin
            state   <= state_nxt;
            ch      <= ch_nxt;
            cnt     <= tick ? '0 : cnt + 1'b1;
            ready_q <= 1'b1;
            if (start)
                pending <= 1'b0;
            else if (tick && busy)
                pending <= 1'b1;
            // Data and strobe launch together so the driver sees stable data for the whole strobe
            if (enter_load)
                pwm_data <= {sel_nd, sel_np};
            pwm_load <= enter_load ? sel : '0;
        end
    end

`ifdef PWM_RAMP_SEQ_IRQ_EN
    logic did_load;
    logic to_idle;

    assign to_idle = (state != IDLE) && (state_nxt == IDLE);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            did_load  <= 1'b0;
            sweep_irq <= 1'b0;
        end else begin
            if (start)
                did_load <= 1'b0;
            else if (enter_load)
                did_load <= 1'b1;
            sweep_irq <= to_idle && did_load && (&settled);
        end
    end
`endif
endmodule
